// File: rtl/drum_event_fifo_spi_slave.sv
// Timestamps per-channel drum triggers, queues them in a FIFO and serialises one frame per MCU load strobe.
// Trigger to mcu_done is 3 clk; full FIFO holds events in per-channel pending slots, a second hit while pending is dropped.
module drum_event_fifo_spi_slave #(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 16,
    parameter int TS_W     = 16,
    parameter int TICK_DIV = 3000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         trig_valid,
    input  logic [4*NUM_CH-1:0]       trig_code,
    input  logic                      mcu_sck,
    input  logic                      mcu_load,
    output logic                      mcu_sdo,
    output logic                      mcu_done,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow
);
    localparam int HAND_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int ENTRY_W    = HAND_W + 4 + TS_W;
    localparam int FRAME_BITS = ((6 + HAND_W + TS_W + 7) / 8) * 8;
    localparam int PS_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BC_W       = $clog2(FRAME_BITS + 2);

    logic [PS_W-1:0]       presc;
    logic [TS_W-1:0]       ts;
    logic [NUM_CH-1:0]     pending;
    logic [3:0]            pend_code [NUM_CH];
    logic [TS_W-1:0]       pend_ts   [NUM_CH];
    logic [HAND_W-1:0]     rr;
    logic [HAND_W-1:0]     win;
    logic                  win_vld;
    logic [NUM_CH-1:0]     grant;
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic                  full, empty, do_push, do_pop, drop;
    logic [2:0]            sck_s, load_s;
    logic                  sck_fall, load_rise, load_fall;
    logic [FRAME_BITS-1:0] sr, frame_new;
    logic [BC_W-1:0]       bit_cnt;
    logic                  frm_vld, frm_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            ts    <= '0;
        end else if (presc == PS_W'(TICK_DIV - 1)) begin
            presc <= '0;
            ts    <= ts + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign drop = |(trig_valid & pending);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_code[i] <= '0;
                pend_ts[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant[i])
                    pending[i] <= 1'b0;
                if (trig_valid[i] && !pending[i]) begin
                    pending[i]   <= 1'b1;
                    pend_code[i] <= trig_code[4*i +: 4];
                    pend_ts[i]   <= ts;
                end
            end
        end
    end

    // Round-robin scan starting at rr; first pending channel wins.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            automatic int idx = (int'(rr) + k) % NUM_CH;
            if (!win_vld && pending[idx]) begin
                win_vld = 1'b1;
                win     = HAND_W'(idx);
            end
        end
    end

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = load_fall && frm_vld && !empty && (bit_cnt == BC_W'(FRAME_BITS));
    assign do_push = win_vld && (!full || do_pop);

    always_comb begin
        grant = '0;
        if (do_push)
            grant[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {win, pend_code[win], pend_ts[win]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr     <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr     <= (win == HAND_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // s[0]/s[1] synchronise, s[2] is the previous synced value for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s  <= '0;
            load_s <= '0;
        end else begin
            sck_s  <= {sck_s[1:0], mcu_sck};
            load_s <= {load_s[1:0], mcu_load};
        end
    end

    assign sck_fall  = sck_s[2] & ~sck_s[1];
    assign load_rise = load_s[1] & ~load_s[2];
    assign load_fall = load_s[2] & ~load_s[1];

    always_comb begin
        frame_new                 = '0;
        frame_new[FRAME_BITS-2]   = overflow;
        if (!empty) begin
            frame_new[FRAME_BITS-1]             = 1'b1;
            frame_new[FRAME_BITS-3 -: ENTRY_W]  = mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
            frm_vld <= 1'b0;
            frm_ovf <= 1'b0;
        end else if (load_rise) begin
            sr      <= frame_new;
            bit_cnt <= '0;
            frm_vld <= !empty;
            frm_ovf <= overflow;
        end else if (sck_fall && load_s[1]) begin
            sr <= sr << 1;
            if (bit_cnt != BC_W'(FRAME_BITS + 1))
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            mcu_done <= 1'b0;
        end else begin
            mcu_done <= !empty;
            if (drop)
                overflow <= 1'b1;
            else if (do_pop && frm_ovf)
                overflow <= 1'b0;
        end
    end

    assign mcu_sdo    = sr[FRAME_BITS-1];
    assign fifo_count = count;
endmodule

// File: tb/tb_drum_event_fifo_spi_slave.sv
// Directed bench for drum_event_fifo_spi_slave; TICK_DIV=1 so the timestamp advances once per clk.
module tb_drum_event_fifo_spi_slave;
    logic        clk = 1'b0;
    logic        rst_n, mcu_sck, mcu_load, mcu_sdo, mcu_done, overflow;
    logic [1:0]  trig_valid;
    logic [7:0]  trig_code;
    logic [4:0]  fifo_count;
    logic [15:0] ts_m;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    drum_event_fifo_spi_slave #(
        .NUM_CH(2), .DEPTH(16), .TS_W(16), .TICK_DIV(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_valid(trig_valid), .trig_code(trig_code),
        .mcu_sck(mcu_sck), .mcu_load(mcu_load), .mcu_sdo(mcu_sdo),
        .mcu_done(mcu_done), .fifo_count(fifo_count), .overflow(overflow)
    );

    // One tick per clk edge out of reset.
    always @(posedge clk) begin
        if (!rst_n) ts_m <= '0;
        else        ts_m <= ts_m + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [23:0] mk(input logic v, input logic o, input logic h,
                                       input logic [3:0] c, input logic [15:0] t);
        return {v, o, h, c, t, 1'b0};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; mcu_load = 1'b0; mcu_sck = 1'b0; trig_valid = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic trig(input logic [1:0] v, input logic [7:0] codes, output logic [15:0] t);
        trig_valid = v;
        trig_code  = codes;
        t          = ts_m;
        @(negedge clk);
        trig_valid = '0;
    endtask

    task automatic wait_ts(input logic [15:0] v);
        int g = 0;
        while (ts_m != v && g < 70000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic load_start();
        mcu_load = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic shift_bits(input int n, inout logic [23:0] d);
        for (int i = 0; i < n; i++) begin
            d = {d[22:0], mcu_sdo};
            mcu_sck = 1'b1;
            repeat (4) @(negedge clk);
            mcu_sck = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic load_end();
        mcu_load = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic read_frame(input int n, output logic [23:0] d);
        logic [23:0] acc = '0;
        load_start();
        shift_bits(n, acc);
        load_end();
        d = acc;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] t, ts0, ts1;
        logic [23:0] d, e;

        rst_n = 1'b0; trig_valid = '0; trig_code = '0; mcu_sck = 1'b0; mcu_load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sdo", 32'(mcu_sdo), 0);
        chk("rst_done", 32'(mcu_done), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;

        // Single hit at ts=5 on channel 0.
        wait_ts(16'd5);
        trig(2'b01, 8'h03, t);
        chk("single_done_t1", 32'(mcu_done), 0);
        @(negedge clk);
        chk("single_done_t2", 32'(mcu_done), 0);
        chk("single_count_t2", 32'(fifo_count), 1);
        @(negedge clk);
        chk("single_done_t3", 32'(mcu_done), 1);
        read_frame(24, d);
        chk("single_frame", 32'(d), 32'(mk(1'b1, 1'b0, 1'b0, 4'h3, 16'd5)));
        chk("single_done_after", 32'(mcu_done), 0);
        chk("single_count_after", 32'(fifo_count), 0);

        // Simultaneous hits on both channels, RR pointer fresh from reset.
        do_reset();
        trig(2'b11, {4'h7, 4'h2}, t);
        repeat (4) @(negedge clk);
        chk("simul_count", 32'(fifo_count), 2);
        read_frame(24, d);
        chk("simul_frame0", 32'(d), 32'(mk(1'b1, 1'b0, 1'b0, 4'h2, t)));
        read_frame(24, d);
        chk("simul_frame1", 32'(d), 32'(mk(1'b1, 1'b0, 1'b1, 4'h7, t)));
        chk("simul_count_after", 32'(fifo_count), 0);

        // Overflow: 17 hits fill 16 slots plus the pending slot; the 18th is dropped.
        do_reset();
        ts0 = '0; ts1 = '0;
        for (int k = 0; k < 17; k++) begin
            trig(2'b01, {4'h0, 4'(k + 1)}, t);
            if (k == 0) ts0 = t;
            if (k == 1) ts1 = t;
            repeat (3) @(negedge clk);
        end
        chk("ovf_count_full", 32'(fifo_count), 16);
        chk("ovf_flag_before", 32'(overflow), 0);
        chk("ovf_done", 32'(mcu_done), 1);
        trig(2'b01, 8'h0F, t);
        repeat (2) @(negedge clk);
        chk("ovf_flag_set", 32'(overflow), 1);
        chk("ovf_count_held", 32'(fifo_count), 16);
        read_frame(24, d);
        chk("ovf_frame", 32'(d), 32'(mk(1'b1, 1'b1, 1'b0, 4'h1, ts0)));
        chk("ovf_flag_cleared", 32'(overflow), 0);
        chk("ovf_count_refill", 32'(fifo_count), 16);

        // Aborted read leaves the head in place.
        e = mk(1'b1, 1'b0, 1'b0, 4'h2, ts1);
        read_frame(10, d);
        chk("abort_bits", 32'(d[9:0]), 32'(e[23:14]));
        chk("abort_count", 32'(fifo_count), 16);
        read_frame(24, d);
        chk("abort_reread", 32'(d), 32'(e));
        chk("abort_count_after", 32'(fifo_count), 15);

        // Empty read.
        do_reset();
        read_frame(24, d);
        chk("empty_frame", 32'(d), 0);
        chk("empty_count", 32'(fifo_count), 0);
        chk("empty_done", 32'(mcu_done), 0);
        chk("empty_ovf", 32'(overflow), 0);

        // Reset after 8 bits of a frame.
        trig(2'b01, 8'h05, t);
        repeat (4) @(negedge clk);
        chk("midrst_count_pre", 32'(fifo_count), 1);
        e = mk(1'b1, 1'b0, 1'b0, 4'h5, t);
        d = '0;
        load_start();
        shift_bits(8, d);
        chk("midrst_bits", 32'(d[7:0]), 32'(e[23:16]));
        chk("midrst_sdo_pre", 32'(mcu_sdo), 32'(e[15]));
        rst_n = 1'b0;
        mcu_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_done", 32'(mcu_done), 0);
        chk("midrst_sdo", 32'(mcu_sdo), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Timestamp wrap: capture exactly at the tick that rolls over to 0.
        do_reset();
        wait_ts(16'hFFFF);
        @(negedge clk);
        trig(2'b10, 8'hA0, t);
        repeat (4) @(negedge clk);
        read_frame(24, d);
        chk("wrap_frame", 32'(d), 32'(mk(1'b1, 1'b0, 1'b1, 4'hA, 16'h0000)));
        chk("wrap_count_after", 32'(fifo_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/drum_event_fifo_spi_slave.md
Name: drum_event_fifo_spi_slave

Overview:
Parametrised successor to the single-event MCU SPI slave. It accepts drum triggers from NUM_CH hand channels and stamps each with a free-running timestamp. Events are queued in a DEPTH-entry FIFO and shifted to the MCU one byte-padded frame per load transaction, so bursts and simultaneous hits are no longer lost. It sits between the drum trigger processor(s) and the MCU SPI pins, in the 3 MHz clk domain.

Parameters:
NUM_CH, 2, number of trigger channels (hands); HAND_W = max(1, clog2(NUM_CH))
DEPTH, 16, FIFO entries (power of two, >=2)
TS_W, 16, timestamp width
TICK_DIV, 3000, clk cycles per timestamp tick (1 ms at 3 MHz)
FRAME_BITS, derived: 6+HAND_W+TS_W rounded up to a multiple of 8 (default 24)

Ports:
clk  in  1  system clock (3 MHz)
rst_n  in  1  reset; synchronous, active-low
trig_valid  in  NUM_CH  per-channel one-cycle trigger pulse
trig_code  in  4*NUM_CH  per-channel drum code; channel i at bits [4i+3:4i]
mcu_sck  in  1  SPI clock from MCU (async; SCK <= clk/8)
mcu_load  in  1  frame-transaction strobe from MCU (async)
mcu_sdo  out  1  serial data to MCU
mcu_done  out  1  high = FIFO non-empty
fifo_count  out  clog2(DEPTH)+1  occupancy (debug)
overflow  out  1  sticky drop flag

Behaviour:
- Reset (rst_n low at a clk edge): FIFO empty, pointers 0, timestamp 0, prescaler 0, pending cleared, RR pointer 0, shift register 0. Outputs: mcu_sdo=0, mcu_done=0, fifo_count=0, overflow=0. Reset mid-transaction abandons the frame; nothing is popped.
- Timestamp: prescaler counts 0..TICK_DIV-1; ts increments on wrap and wraps modulo 2^TS_W.
- Capture: trig_valid[i] at cycle t sets pending[i] and latches code and ts(t) at t+1. If pending[i] is already set, the new event is dropped and overflow is set.
- Arbiter: each cycle, at most one pending channel is written to the FIFO. Selection is round-robin starting at RR pointer; the pointer moves to winner+1 mod NUM_CH. Entry = {hand, code, ts}.
- FIFO write blocked when full. Pending entries wait and are not dropped. Simultaneous push and pop while full is allowed: the pop frees the slot in the same cycle.
- mcu_done is registered !empty. Earliest assertion: t+3 after a trigger into an empty FIFO.
- SPI sync: mcu_sck and mcu_load each pass through a 2-flop synchroniser, followed by edge detect.
- load rise: shift register loads frame {valid, ovf, hand, code, ts, zero pad}, MSB first.
  - valid = !empty; ovf = overflow.
  - When empty, the frame carries valid=0 with all other bits 0 except ovf.
  - Bit counter clears to 0. mcu_sdo = frame MSB.
- sck fall (load high): shift left, increment bit counter, mcu_sdo = next bit. The MCU samples on sck rise.
- load fall: if bit counter == FRAME_BITS and valid was 1, pop the FIFO. If also ovf was 1, clear overflow, unless a new drop occurs in the same cycle; the drop wins.
  - Short or aborted transaction: no pop, no clear.
  - Reading an empty frame never pops.
- sck edges while load is low are ignored. mcu_sdo holds the last value.
- fifo_count is always within 0..DEPTH, and pointers wrap modulo DEPTH.

Test Plan:
- Single hit: reset, trig_valid=01, code ch0=4'h3 at ts=5 -> mcu_done rises at t+3; 24-bit read = {1,0,0,4'h3,16'h0005,0 pad}; after load falls, done=0 and fifo_count=0.
- Simultaneous: trig_valid=11 with codes 2 and 7, RR pointer 0 -> two frames read in order hand0/code2 then hand1/code7, both with the same ts.
- Overflow: 17 hits on ch0 spaced 4 cycles apart, DEPTH=16, no reads -> 16 entries, the 17th stays pending; an 18th hit sets overflow=1. The first read frame has ovf=1, and overflow clears after a full read.
- Aborted read: load high, 10 sck pulses, load low -> no pop, fifo_count unchanged; the next full read returns the same frame.
- Empty read: 24 clocks with FIFO empty -> all-zero frame, no state change.
- Reset mid-frame, plus timestamp wrap: rst_n low after 8 bits -> count=0, done=0, sdo=0. Separately, run 65536 ticks -> ts wraps to 0, and a captured event reports ts=0.
